// File: rtl/find_inv_pkg.sv
// Shared types and the bit-sliced witness function for the serial
// invertibility witness generator.
package find_inv_pkg;

    typedef enum logic {
        OP_AND = 1'b0,
        OP_OR  = 1'b1
    } op_e;

    typedef enum logic {
        PRED_EQ = 1'b0,
        PRED_NE = 1'b1
    } pred_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic t_any;
        logic t_all;
        logic s_any;
        logic s_all;
        logic viol;
    } flags_t;

    typedef struct packed {
        logic sat;
        logic x;
    } witness_t;

    // AND/OR reductions start from their neutral values on every accept.
    localparam flags_t ACC_INIT = '{t_any: 1'b0, t_all: 1'b1, s_any: 1'b0,
                                    s_all: 1'b1, viol: 1'b0};

    // Evaluated once per witness bit: every x formula is bitwise in t,
    // so the function stays independent of the operand width.
    function automatic witness_t inv_witness(input op_e op, input pred_e pred,
                                             input flags_t f, input logic t);
        witness_t w;
        w.sat = ~f.viol;
        w.x   = t;
        if (pred == PRED_NE) begin
            if (op == OP_AND) begin
                w.sat = f.s_any | f.t_any;
                w.x   = f.t_any ? ~t : 1'b1;
            end else begin
                w.sat = ~(f.s_all & f.t_all);
                w.x   = f.t_all ? 1'b0 : ~t;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/find_inv_lane_reduce.sv
// Combinational reduction of one LANE-bit slice of s and t into the
// partial flags accumulated by the serial scanner.
module find_inv_lane_reduce
    import find_inv_pkg::*;
#(
    parameter int LANE = 2
) (
    input  logic [LANE-1:0] s,
    input  logic [LANE-1:0] t,
    input  logic [LANE-1:0] mask,
    input  logic            op,
    output logic            t_any,
    output logic            t_all,
    output logic            s_any,
    output logic            s_all,
    output logic            viol
);

    // Masked-off bits read as 1 for the all-reductions and 0 for the rest.
    always_comb begin
        t_any = |(t & mask);
        t_all = &(t | ~mask);
        s_any = |(s & mask);
        s_all = &(s | ~mask);
        if (op == OP_AND) begin
            viol = |(t & ~s & mask);
        end else begin
            viol = |(s & ~t & mask);
        end
    end

endmodule

// File: rtl/find_inv_bvlogic_serial.sv
// Serial witness generator for (x OP s) PRED t, OP in {AND,OR}, PRED in {EQ,NE};
// scans LANE bits per cycle and presents x/sat behind a valid/ready pair.
module find_inv_bvlogic_serial
    import find_inv_pkg::*;
#(
    parameter int W    = 8,
    parameter int LANE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_t,
    input  logic         in_op,
    input  logic         in_pred,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic         out_sat,
    output logic         busy
);

    localparam int NBEAT = (W + LANE - 1) / LANE;
    localparam int PW    = NBEAT * LANE;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   s_q, t_q, s_pad, t_pad;
    op_e             op_q;
    pred_e           pred_q;
    logic [BW-1:0]   beat_q;
    flags_t          acc_q, acc_nxt, part;
    logic [LANE-1:0] lane_s, lane_t, lane_mask;
    logic [W-1:0]    x_nxt, x_q;
    logic            sat_nxt, sat_q;
    logic            accept, last;

    // Operands are zero-padded to a whole number of beats; the lane mask
    // hides the padding from the reductions.
    always_comb begin
        s_pad        = '0;
        t_pad        = '0;
        s_pad[W-1:0] = in_s;
        t_pad[W-1:0] = in_t;
    end

    always_comb begin
        lane_s = s_q[beat_q*LANE +: LANE];
        lane_t = t_q[beat_q*LANE +: LANE];
        for (int i = 0; i < LANE; i++) begin
            lane_mask[i] = (int'(beat_q) * LANE + i) < W;
        end
    end

    find_inv_lane_reduce #(
        .LANE(LANE)
    ) u_reduce (
        .s     (lane_s),
        .t     (lane_t),
        .mask  (lane_mask),
        .op    (op_q),
        .t_any (part.t_any),
        .t_all (part.t_all),
        .s_any (part.s_any),
        .s_all (part.s_all),
        .viol  (part.viol)
    );

    always_comb begin
        acc_nxt.t_any = acc_q.t_any | part.t_any;
        acc_nxt.t_all = acc_q.t_all & part.t_all;
        acc_nxt.s_any = acc_q.s_any | part.s_any;
        acc_nxt.s_all = acc_q.s_all & part.s_all;
        acc_nxt.viol  = acc_q.viol  | part.viol;
    end

    // Witness uses the flags including the final beat so it can be
    // registered on the SCAN->DONE edge.
    always_comb begin
        witness_t w;
        x_nxt   = '0;
        sat_nxt = 1'b0;
        for (int i = 0; i < W; i++) begin
            w        = inv_witness(op_q, pred_q, acc_nxt, t_q[i]);
            x_nxt[i] = w.x;
            sat_nxt  = w.sat;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (beat_q == LAST_BEAT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            t_q    <= '0;
            op_q   <= OP_AND;
            pred_q <= PRED_EQ;
            beat_q <= '0;
            acc_q  <= '0;
            x_q    <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (accept) begin
                s_q    <= s_pad;
                t_q    <= t_pad;
                op_q   <= op_e'(in_op);
                pred_q <= pred_e'(in_pred);
                beat_q <= '0;
                acc_q  <= ACC_INIT;
            end else if (state_q == SCAN) begin
                acc_q <= acc_nxt;
                if (!last) begin
                    beat_q <= beat_q + 1'b1;
                end
            end
            if (last) begin
                x_q   <= x_nxt;
                sat_q <= sat_nxt;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_x     = x_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_find_inv_bvlogic_serial.sv
// Directed and brute-force checks of find_inv_bvlogic_serial in three
// width/lane configurations sharing one clock and reset.
module tb_find_inv_bvlogic_serial;

    logic       clk;
    logic       rst;
    logic [7:0] s_bus, t_bus;
    logic       op_bus, pred_bus;
    logic [2:0] iv, ir, ov, orr, osat, bz;
    logic [7:0] ox0;
    logic [3:0] ox1;
    logic [6:0] ox2;
    logic [7:0] ox_all [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] t;
        logic       op;
        logic       pred;
        logic [7:0] x;
        logic       sat;
    } vec_t;

    assign ox_all[0] = ox0;
    assign ox_all[1] = {4'b0, ox1};
    assign ox_all[2] = {1'b0, ox2};

    find_inv_bvlogic_serial #(.W(8), .LANE(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_s(s_bus), .in_t(t_bus), .in_op(op_bus), .in_pred(pred_bus),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_x(ox0), .out_sat(osat[0]),
        .busy(bz[0]));

    find_inv_bvlogic_serial #(.W(4), .LANE(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_s(s_bus[3:0]), .in_t(t_bus[3:0]), .in_op(op_bus), .in_pred(pred_bus),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_x(ox1), .out_sat(osat[1]),
        .busy(bz[1]));

    find_inv_bvlogic_serial #(.W(7), .LANE(3)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_s(s_bus[6:0]), .in_t(t_bus[6:0]), .in_op(op_bus), .in_pred(pred_bus),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_x(ox2), .out_sat(osat[2]),
        .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: does (x OP s) PRED t hold in the low w bits?
    function automatic logic holds(input int w, input logic [7:0] x, input logic [7:0] s,
                                   input logic [7:0] t, input logic op, input logic pred);
        logic [7:0] m, r;
        m = 8'((1 << w) - 1);
        r = op ? (x | s) : (x & s);
        return pred ? ((r & m) != (t & m)) : ((r & m) == (t & m));
    endfunction

    function automatic logic exists_x(input int w, input logic [7:0] s, input logic [7:0] t,
                                      input logic op, input logic pred);
        for (int i = 0; i < (1 << w); i++) begin
            if (holds(w, 8'(i), s, t, op, pred)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One full request: accept, count latency, optionally stall the
    // consumer for rgap cycles, then release and confirm return to IDLE.
    task automatic applyStimulus(input int sel, input logic [7:0] s, input logic [7:0] t,
                                 input logic op, input logic pred,
                                 input int vgap, input int rgap,
                                 output logic [7:0] x, output logic sat,
                                 output int lat, output int hold_err);
        int n;
        x        = '0;
        sat      = 1'b0;
        lat      = 0;
        hold_err = 0;
        repeat (vgap) step();
        s_bus    = s;
        t_bus    = t;
        op_bus   = op;
        pred_bus = pred;
        iv[sel]  = 1'b1;
        n = 0;
        while (!ir[sel] && n < 50) begin
            step();
            n++;
        end
        step();
        iv[sel]  = 1'b0;
        s_bus    = ~s;
        t_bus    = 8'($urandom);
        op_bus   = ~op;
        pred_bus = ~pred;
        lat = 1;
        while (!ov[sel] && lat < 50) begin
            step();
            lat++;
        end
        if (!ov[sel]) begin
            checkOutput("out_valid_timeout", 32'(ov[sel]), 32'd1);
            return;
        end
        x   = ox_all[sel];
        sat = osat[sel];
        repeat (rgap) begin
            step();
            if (!ov[sel] || ir[sel] || ox_all[sel] !== x || osat[sel] !== sat) hold_err++;
        end
        orr[sel] = 1'b1;
        step();
        orr[sel] = 1'b0;
        checkOutput("release_valid", 32'(ov[sel]), 32'd0);
        checkOutput("release_ready", 32'(ir[sel]), 32'd1);
    endtask

    initial begin
        vec_t       dv [9];
        vec_t       d7 [3];
        logic [7:0] x;
        logic       sat;
        int         lat, he, seen;
        logic [7:0] rs, rt;
        logic       rop, rpred;

        // s, t, op(0=AND), pred(0=EQ), expected x, expected sat
        dv[0] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
        dv[1] = '{8'h00, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b1};
        dv[2] = '{8'h0F, 8'h13, 1'b0, 1'b0, 8'h13, 1'b0};
        dv[3] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0};
        dv[4] = '{8'hFE, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1};
        dv[5] = '{8'hFF, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1};
        dv[6] = '{8'h11, 8'h33, 1'b1, 1'b0, 8'h33, 1'b1};
        dv[7] = '{8'h80, 8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0};
        dv[8] = '{8'h01, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1};
        d7[0] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 8'h00, 1'b0};
        d7[1] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0};
        d7[2] = '{8'h7F, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1};

        rst = 1'b1;
        iv = '0; orr = '0;
        s_bus = '0; t_bus = '0; op_bus = 1'b0; pred_bus = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_out_valid", 32'(ov[k]), 32'd0);
            checkOutput("reset_in_ready", 32'(ir[k]), 32'd1);
            checkOutput("reset_busy", 32'(bz[k]), 32'd0);
            checkOutput("reset_out_x", 32'(ox_all[k]), 32'd0);
            checkOutput("reset_out_sat", 32'(osat[k]), 32'd0);
        end
        rst = 1'b0;
        step();

        $display("[TB] directed W=8 LANE=2");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, dv[i].s, dv[i].t, dv[i].op, dv[i].pred, 0, 0, x, sat, lat, he);
            checkOutput("w8_sat", 32'(sat), 32'(dv[i].sat));
            checkOutput("w8_x", 32'(x), 32'(dv[i].x));
            checkOutput("w8_latency", 32'(lat), 32'd5);
        end

        $display("[TB] back-pressure hold");
        applyStimulus(0, 8'h00, 8'h3C, 1'b0, 1'b1, 0, 10, x, sat, lat, he);
        checkOutput("hold_stable", 32'(he), 32'd0);
        checkOutput("hold_x", 32'(x), 32'hC3);
        checkOutput("hold_sat", 32'(sat), 32'd1);

        $display("[TB] directed W=7 LANE=3");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, d7[i].s, d7[i].t, d7[i].op, d7[i].pred, 0, 0, x, sat, lat, he);
            checkOutput("w7_sat", 32'(sat), 32'(d7[i].sat));
            checkOutput("w7_x", 32'(x), 32'(d7[i].x));
            checkOutput("w7_latency", 32'(lat), 32'd4);
        end

        $display("[TB] reset during SCAN");
        s_bus = 8'h2A; t_bus = 8'h15; op_bus = 1'b0; pred_bus = 1'b1;
        iv[2] = 1'b1;
        step();
        iv[2] = 1'b0;
        checkOutput("abort_busy_before", 32'(bz[2]), 32'd1);
        step();
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(ov[2]), 32'd0);
        checkOutput("abort_in_ready", 32'(ir[2]), 32'd1);
        checkOutput("abort_busy", 32'(bz[2]), 32'd0);
        checkOutput("abort_out_x", 32'(ox_all[2]), 32'd0);
        checkOutput("abort_out_sat", 32'(osat[2]), 32'd0);
        step();
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            step();
            if (ov[2]) seen++;
        end
        checkOutput("abort_no_output", 32'(seen), 32'd0);
        applyStimulus(2, 8'h00, 8'h3C, 1'b0, 1'b1, 0, 0, x, sat, lat, he);
        checkOutput("after_abort_sat", 32'(sat), 32'd1);
        checkOutput("after_abort_x", 32'(x), 32'h43);
        checkOutput("after_abort_latency", 32'(lat), 32'd4);

        $display("[TB] exhaustive W=4 LANE=4");
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 16; t++) begin
                for (int m = 0; m < 4; m++) begin
                    applyStimulus(1, 8'(s), 8'(t), m[1], m[0], 0, 0, x, sat, lat, he);
                    checkOutput("w4_sat", 32'(sat), 32'(exists_x(4, 8'(s), 8'(t), m[1], m[0])));
                    checkOutput("w4_latency", 32'(lat), 32'd2);
                    if (sat) begin
                        checkOutput("w4_witness", 32'(holds(4, x, 8'(s), 8'(t), m[1], m[0])), 32'd1);
                    end
                end
            end
        end

        $display("[TB] random W=7 LANE=3");
        for (int r = 0; r < 10000; r++) begin
            rs    = 8'($urandom_range(0, 127));
            rt    = 8'($urandom_range(0, 127));
            rop   = 1'($urandom_range(0, 1));
            rpred = 1'($urandom_range(0, 1));
            applyStimulus(2, rs, rt, rop, rpred, $urandom_range(0, 1), $urandom_range(0, 1),
                          x, sat, lat, he);
            checkOutput("w7r_sat", 32'(sat), 32'(exists_x(7, rs, rt, rop, rpred)));
            checkOutput("w7r_latency", 32'(lat), 32'd4);
            checkOutput("w7r_hold", 32'(he), 32'd0);
            if (sat) begin
                checkOutput("w7r_witness", 32'(holds(7, x, rs, rt, rop, rpred)), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
